spi_program_loader: RTL and testbench

SPI_PROGRAM_LOADER -- requirements
Module: spi_program_loader

---
 rtl/spi_program_loader.sv | 166 ++++++++++++++++
 tb/tb_spi_program_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_program_loader.sv
// Host-driven loader: writes cache words to the processor over a 12-bit serial frame
// and supervises processor runs with a cycle counter and a timeout.
module spi_program_loader #(
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic [1:0]  mode_out,
    output logic        mosi_out,
    input  logic        proc_done_in,
    output logic        busy,
    output logic        run_done,
    output logic [15:0] run_cycles,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        RUN_START,
        RUN_WAIT
    } state_t;

    localparam logic [3:0]  GAP_LAST     = 4'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [11:0] frame_q, frame_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        run_done_q, run_done_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic        timeout_q, timeout_d;
    logic [15:0] run_cycles_inc;

    assign run_cycles_inc = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        op_d         = op_q;
        bitcnt_d     = bitcnt_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        run_done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    timeout_d = 1'b0;
                    case (cmd_op)
                        2'b01, 2'b10: begin
                            frame_d  = {cmd_data, cmd_addr};
                            op_d     = cmd_op;
                            bitcnt_d = '0;
                            state_d  = SHIFT;
                        end
                        2'b11: begin
                            run_cycles_d = '0;
                            state_d      = RUN_START;
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                if (bitcnt_q == 4'd11) begin
                    bitcnt_d = '0;
                    state_d  = GAP;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            // bitcnt is reused as the gap-cycle counter
            GAP: begin
                if (bitcnt_q == GAP_LAST) begin
                    bitcnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            RUN_START: begin
                run_cycles_d = run_cycles_inc;
                state_d      = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (proc_done_in) begin
                    run_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    run_cycles_d = run_cycles_inc;
                    if (run_cycles_q == TIMEOUT_LAST) begin
                        timeout_d  = 1'b1;
                        run_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output flops are loaded from the next-state values so they line up with state_q
        mode_d = 2'b00;
        mosi_d = 1'b0;
        case (state_d)
            SHIFT: begin
                mode_d = op_d;
                mosi_d = frame_d[bitcnt_d];
            end
            RUN_START, RUN_WAIT: mode_d = 2'b11;
            default: ;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            op_q         <= '0;
            bitcnt_q     <= '0;
            mode_q       <= '0;
            mosi_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            op_q         <= op_d;
            bitcnt_q     <= bitcnt_d;
            mode_q       <= mode_d;
            mosi_q       <= mosi_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            run_done_q   <= run_done_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
        end
    end

    // Run enable drops in the very cycle done rises so the processor cannot restart
    assign mode_out   = (state_q == RUN_WAIT && proc_done_in) ? 2'b00 : mode_q;
    assign mosi_out   = mosi_q;
    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign run_done   = run_done_q;
    assign run_cycles = run_cycles_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_spi_program_loader.sv
// Self-checking bench: each command is expanded into its expected per-cycle output trace,
// and the next command is always presented while the current one is busy.
module tb_spi_program_loader;

    localparam int unsigned TB_GAP = 3;
    localparam int unsigned TB_TO  = 16;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [1:0]  mode_out;
    logic        mosi_out;
    logic        proc_done_in;
    logic        busy;
    logic        run_done;
    logic [15:0] run_cycles;
    logic        timeout;

    spi_program_loader #(
        .GAP_CYCLES    (TB_GAP),
        .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .mode_out    (mode_out),
        .mosi_out    (mosi_out),
        .proc_done_in(proc_done_in),
        .busy        (busy),
        .run_done    (run_done),
        .run_cycles  (run_cycles),
        .timeout     (timeout)
    );

    typedef struct packed {
        logic       valid;
        logic [1:0] op;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] dly;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic        mosi;
        logic        busy;
        logic        rdone;
        logic [15:0] rc;
        logic        to;
        logic        done;
    } exp_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  trace[$];
    cmd_t  cmds[$];
    int    exp_rc = 0;
    logic  exp_to = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic v, input logic [1:0] op, input logic [3:0] a,
                                input logic [7:0] d, input logic [7:0] dly);
        cmd_t c;
        c.valid = v; c.op = op; c.addr = a; c.data = d; c.dly = dly;
        return c;
    endfunction

    task automatic drive(input cmd_t c);
        cmd_valid = c.valid;
        cmd_op    = c.op;
        cmd_addr  = c.addr;
        cmd_data  = c.data;
    endtask

    task automatic add(input logic [1:0] mode, input logic mosi, input logic bsy,
                       input logic rdone, input logic done);
        exp_t e;
        e.mode = mode; e.mosi = mosi; e.busy = bsy; e.rdone = rdone;
        e.rc = 16'(exp_rc); e.to = exp_to; e.done = done;
        trace.push_back(e);
    endtask

    // Expected trace: one entry per cycle after the accepting edge, ending in the first IDLE cycle
    task automatic build(input cmd_t c);
        logic [11:0] frame;
        trace.delete();
        if (!c.valid || c.op == 2'b00) begin
            if (c.valid) exp_to = 1'b0;
            add(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end else if (c.op != 2'b11) begin
            exp_to = 1'b0;
            frame  = {c.data, c.addr};
            for (int i = 0; i < 12; i++) add(c.op, frame[i], 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < int'(TB_GAP); i++) add(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
            add(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            exp_to = 1'b0;
            if (int'(c.dly) <= int'(TB_TO) - 2) begin
                exp_rc = 0;
                add(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
                for (int k = 1; k <= int'(c.dly); k++) begin
                    exp_rc = k;
                    add(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
                end
                exp_rc = 1 + int'(c.dly);
                add(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
                add(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
                for (int k = 0; k < int'(TB_TO); k++) begin
                    exp_rc = k;
                    add(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
                end
                exp_rc = int'(TB_TO);
                exp_to = 1'b1;
                add(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic cmp(input exp_t e);
        check("mode",       32'(mode_out),   32'(e.mode));
        check("mosi",       32'(mosi_out),   32'(e.mosi));
        check("busy",       32'(busy),       32'(e.busy));
        check("cmd_ready",  32'(cmd_ready),  32'(!e.busy));
        check("run_done",   32'(run_done),   32'(e.rdone));
        check("run_cycles", 32'(run_cycles), 32'(e.rc));
        check("timeout",    32'(timeout),    32'(e.to));
    endtask

    task automatic run_trace(input cmd_t nxt);
        foreach (trace[i]) begin
            @(posedge clk);
            #1;
            drive(nxt);
            proc_done_in = trace[i].done;
            #1;
            cmp(trace[i]);
        end
    endtask

    initial begin
        cmd_t none;
        cmd_t w;
        none         = mk(1'b0, 2'b00, 4'h0, 8'h00, 8'd0);
        rst          = 1'b1;
        proc_done_in = 1'b1;
        drive(none);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mode",       32'(mode_out),   32'd0);
        check("rst_mosi",       32'(mosi_out),   32'd0);
        check("rst_ready",      32'(cmd_ready),  32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_run_done",   32'(run_done),   32'd0);
        check("rst_run_cycles", 32'(run_cycles), 32'd0);
        check("rst_timeout",    32'(timeout),    32'd0);

        cmds.push_back(mk(1'b1, 2'b01, 4'h3, 8'hA5, 8'd0));
        cmds.push_back(mk(1'b1, 2'b10, 4'hF, 8'h80, 8'd0));
        cmds.push_back(mk(1'b1, 2'b10, 4'h0, 8'h5A, 8'd0));
        cmds.push_back(mk(1'b1, 2'b11, 4'h0, 8'h00, 8'd6));
        cmds.push_back(mk(1'b1, 2'b01, 4'h9, 8'h3C, 8'd0));
        cmds.push_back(mk(1'b1, 2'b11, 4'h0, 8'h00, 8'd99));
        cmds.push_back(mk(1'b1, 2'b00, 4'h0, 8'h00, 8'd0));
        cmds.push_back(mk(1'b1, 2'b11, 4'h0, 8'h00, 8'd0));
        cmds.push_back(mk(1'b1, 2'b11, 4'h0, 8'h00, 8'(TB_TO - 2)));
        cmds.push_back(mk(1'b1, 2'b11, 4'h0, 8'h00, 8'(TB_TO - 1)));
        cmds.push_back(none);
        for (int i = 0; i < 70; i++) begin
            cmds.push_back(mk(($urandom_range(0, 9) != 0), 2'($urandom), 4'($urandom),
                              8'($urandom), 8'($urandom_range(0, TB_TO + 3))));
        end

        drive(cmds[0]);
        for (int i = 0; i < cmds.size(); i++) begin
            build(cmds[i]);
            run_trace((i + 1 < cmds.size()) ? cmds[i + 1] : none);
        end

        // Reset in the middle of a frame, at the cycle carrying bit 5
        w = mk(1'b1, 2'b10, 4'h6, 8'hC3, 8'd0);
        drive(w);
        build(w);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            drive(none);
            proc_done_in = 1'b1;
            #1;
            check("pre_rst_mode", 32'(mode_out), 32'(trace[i].mode));
            check("pre_rst_mosi", 32'(mosi_out), 32'(trace[i].mosi));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_rc = 0;
        exp_to = 1'b0;
        check("abort_mode",  32'(mode_out),  32'd0);
        check("abort_mosi",  32'(mosi_out),  32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy",  32'(busy),      32'd0);
        w = mk(1'b1, 2'b01, 4'hB, 8'h96, 8'd0);
        drive(w);
        build(w);
        run_trace(none);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
